// File: rtl/register_bank.sv
// rtl/register_bank.sv - double-buffered register bank with shadow/active banks and two registered read ports
module register_bank #(
    parameter int NrOfBits = 8,
    parameter int NrOfRegs = 4,
    parameter int AddrBits = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clock_enable,
    input  logic                i_tick,
    input  logic                i_wr_en,
    input  logic [AddrBits-1:0] i_wr_addr,
    input  logic [NrOfBits-1:0] i_wr_data,
    input  logic [NrOfBits-1:0] i_wr_mask,
    input  logic                i_commit,
    input  logic                i_clear,
    input  logic                i_preset,
    input  logic                i_rd_en_a,
    input  logic [AddrBits-1:0] i_rd_addr_a,
    input  logic                i_rd_en_b,
    input  logic [AddrBits-1:0] i_rd_addr_b,
    output logic [NrOfBits-1:0] o_qa,
    output logic [NrOfBits-1:0] o_qb,
    output logic                o_valid_a,
    output logic                o_valid_b,
    output logic                o_dirty
);

    // Register count expressed in AddrBits+1 bits so the range check needs no width juggling.
    localparam logic [AddrBits:0] LP_NREGS = NrOfRegs[AddrBits:0];

    logic [NrOfBits-1:0] r_shadow [NrOfRegs];
    logic [NrOfBits-1:0] r_active [NrOfRegs];
    logic [NrOfBits-1:0] r_qa;
    logic [NrOfBits-1:0] r_qb;
    logic                r_valid_a;
    logic                r_valid_b;
    logic                r_dirty;

    logic                w_step;
    logic                w_wr_valid;
    logic [NrOfBits-1:0] w_rd_a;
    logic [NrOfBits-1:0] w_rd_b;

    assign w_step     = i_clock_enable & i_tick;
    assign w_wr_valid = i_wr_en & ({1'b0, i_wr_addr} < LP_NREGS);

    // Active-bank read muxes; an address with no matching register yields zero.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < NrOfRegs; i++) begin
            if (i_rd_addr_a == AddrBits'(i)) begin
                w_rd_a = r_active[i];
            end
            if (i_rd_addr_b == AddrBits'(i)) begin
                w_rd_b = r_active[i];
            end
        end
    end

    // Bank and dirty-flag update: only on a step, Clear over Preset over Commit/Write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NrOfRegs; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_dirty <= 1'b0;
        end else if (w_step) begin
            if (i_clear) begin
                for (int i = 0; i < NrOfRegs; i++) begin
                    r_shadow[i] <= '0;
                    r_active[i] <= '0;
                end
                r_dirty <= 1'b0;
            end else if (i_preset) begin
                for (int i = 0; i < NrOfRegs; i++) begin
                    r_shadow[i] <= '1;
                    r_active[i] <= '1;
                end
                r_dirty <= 1'b0;
            end else begin
                // Commit copies the pre-write shadow; a same-step write lands in shadow only.
                for (int i = 0; i < NrOfRegs; i++) begin
                    if (i_commit) begin
                        r_active[i] <= r_shadow[i];
                    end
                    if (w_wr_valid && (i_wr_addr == AddrBits'(i))) begin
                        r_shadow[i] <= (r_shadow[i] & ~i_wr_mask) | (i_wr_data & i_wr_mask);
                    end
                end
                if (w_wr_valid) begin
                    r_dirty <= 1'b1;
                end else if (i_commit) begin
                    r_dirty <= 1'b0;
                end
            end
        end
    end

    // Read port A: registered data held when idle, valid pulses per read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_qa      <= '0;
            r_valid_a <= 1'b0;
        end else begin
            r_valid_a <= i_rd_en_a;
            if (i_rd_en_a) begin
                r_qa <= w_rd_a;
            end
        end
    end

    // Read port B: identical to port A, independent address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_qb      <= '0;
            r_valid_b <= 1'b0;
        end else begin
            r_valid_b <= i_rd_en_b;
            if (i_rd_en_b) begin
                r_qb <= w_rd_b;
            end
        end
    end

    assign o_qa      = r_qa;
    assign o_qb      = r_qb;
    assign o_valid_a = r_valid_a;
    assign o_valid_b = r_valid_b;
    assign o_dirty   = r_dirty;

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - directed and randomized checks of register_bank against a behavioural model
module tb_register_bank;

    localparam int NREGS = 3;

    logic       clk;
    logic       rst_n;
    logic       ce, tk, wr_en, commit, clear, preset, rd_en_a, rd_en_b;
    logic [1:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [7:0] wr_data, wr_mask;
    logic [7:0] qa, qb;
    logic       valid_a, valid_b, dirty;

    logic [7:0] m_shadow [NREGS];
    logic [7:0] m_active [NREGS];
    logic [7:0] m_qa, m_qb;
    logic       m_va, m_vb, m_dirty;

    int tests = 0;
    int fails = 0;

    register_bank #(.NrOfBits(8), .NrOfRegs(NREGS), .AddrBits(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clock_enable(ce), .i_tick(tk),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_mask(wr_mask),
        .i_commit(commit), .i_clear(clear), .i_preset(preset),
        .i_rd_en_a(rd_en_a), .i_rd_addr_a(rd_addr_a), .i_rd_en_b(rd_en_b), .i_rd_addr_b(rd_addr_b),
        .o_qa(qa), .o_qb(qb), .o_valid_a(valid_a), .o_valid_b(valid_b), .o_dirty(dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = 8'h00;
        end
        m_qa = 8'h00; m_qb = 8'h00; m_va = 1'b0; m_vb = 1'b0; m_dirty = 1'b0;
    endtask

    task automatic idle();
        ce = 1'b0; tk = 1'b0; wr_en = 1'b0; commit = 1'b0; clear = 1'b0; preset = 1'b0;
        rd_en_a = 1'b0; rd_en_b = 1'b0; wr_addr = 2'd0; rd_addr_a = 2'd0; rd_addr_b = 2'd0;
        wr_data = 8'h00; wr_mask = 8'h00;
    endtask

    // Apply the register bank rules to the model for one rising edge (inputs are stable).
    task automatic model_edge();
        logic [7:0] old_shadow [NREGS];
        bit wv;
        if (rd_en_a) begin
            m_qa = (int'(rd_addr_a) < NREGS) ? m_active[rd_addr_a] : 8'h00;
        end
        if (rd_en_b) begin
            m_qb = (int'(rd_addr_b) < NREGS) ? m_active[rd_addr_b] : 8'h00;
        end
        m_va = rd_en_a;
        m_vb = rd_en_b;
        if (ce && tk) begin
            if (clear || preset) begin
                for (int i = 0; i < NREGS; i++) begin
                    m_shadow[i] = clear ? 8'h00 : 8'hFF;
                    m_active[i] = clear ? 8'h00 : 8'hFF;
                end
                m_dirty = 1'b0;
            end else begin
                old_shadow = m_shadow;
                wv = wr_en && (int'(wr_addr) < NREGS);
                if (commit) m_active = old_shadow;
                if (wv) m_shadow[wr_addr] = (old_shadow[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
                if (wv) m_dirty = 1'b1;
                else if (commit) m_dirty = 1'b0;
            end
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".qa"}, qa, m_qa);
        chk({tag, ".qb"}, qb, m_qb);
        chk({tag, ".va"}, {7'd0, valid_a}, {7'd0, m_va});
        chk({tag, ".vb"}, {7'd0, valid_b}, {7'd0, m_vb});
        chk({tag, ".dirty"}, {7'd0, dirty}, {7'd0, m_dirty});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        cmp_model(tag);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic [7:0] m,
                      input logic c, input logic t);
        idle(); ce = 1'b1; tk = t; wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m; commit = c;
    endtask

    task automatic do_commit();
        idle(); ce = 1'b1; tk = 1'b1; commit = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [1:0] b);
        idle(); rd_en_a = 1'b1; rd_addr_a = a; rd_en_b = 1'b1; rd_addr_b = b;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        #12;
        cmp_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Double buffer: write is invisible until commit
        wr(2'd2, 8'hA5, 8'hFF, 1'b0, 1'b1); rd_en_a = 1'b1; rd_addr_a = 2'd2; step("db_wr");
        chk("db_dirty_set", {7'd0, dirty}, 8'd1);
        rd(2'd2, 2'd2); step("db_rd_pre");
        chk("db_rd_pre_const", qa, 8'h00);
        do_commit(); step("db_commit");
        chk("db_dirty_clr", {7'd0, dirty}, 8'd0);
        rd(2'd2, 2'd0); step("db_rd_post");
        chk("db_rd_post_const", qa, 8'hA5);

        // Mask and tick gating
        wr(2'd1, 8'hFF, 8'hFF, 1'b0, 1'b1); step("mk_fill");
        do_commit(); step("mk_c0");
        wr(2'd1, 8'h00, 8'h0F, 1'b0, 1'b0); step("mk_notick");
        chk("mk_notick_dirty", {7'd0, dirty}, 8'd0);
        wr(2'd1, 8'h00, 8'h0F, 1'b0, 1'b1); step("mk_wr");
        do_commit(); step("mk_c1");
        rd(2'd1, 2'd1); step("mk_rd");
        chk("mk_rd_const", qa, 8'hF0);

        // Commit and write in the same step
        wr(2'd0, 8'h11, 8'hFF, 1'b0, 1'b1); step("cw_w0");
        do_commit(); step("cw_c0");
        wr(2'd0, 8'h22, 8'hFF, 1'b1, 1'b1); step("cw_wc");
        chk("cw_dirty_kept", {7'd0, dirty}, 8'd1);
        rd(2'd0, 2'd0); step("cw_rd1");
        chk("cw_rd1_const", qa, 8'h11);
        do_commit(); step("cw_c1");
        chk("cw_dirty_clr", {7'd0, dirty}, 8'd0);
        rd(2'd0, 2'd0); step("cw_rd2");
        chk("cw_rd2_const", qb, 8'h22);

        // Priority: Clear beats everything, then Preset alone
        wr(2'd1, 8'h5A, 8'hFF, 1'b1, 1'b1); clear = 1'b1; preset = 1'b1; step("pr_all");
        chk("pr_all_dirty", {7'd0, dirty}, 8'd0);
        rd(2'd0, 2'd1); step("pr_rd0");
        chk("pr_rd0_const", qb, 8'h00);
        idle(); ce = 1'b1; tk = 1'b1; preset = 1'b1; step("pr_preset");
        rd(2'd2, 2'd2); step("pr_rd1");
        chk("pr_rd1_const", qa, 8'hFF);

        // Boundary: out-of-range write and reads, same-address dual read
        wr(2'd3, 8'h12, 8'hFF, 1'b0, 1'b1); step("bd_wr3");
        chk("bd_wr3_dirty", {7'd0, dirty}, 8'd0);
        rd(2'd3, 2'd3); step("bd_rd3");
        chk("bd_rd3_qa", qa, 8'h00);
        chk("bd_rd3_qb", qb, 8'h00);
        rd(2'd1, 2'd1); step("bd_dual");
        chk("bd_dual_same", qa, qb);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ce = ($urandom_range(0, 3) != 0);
            tk = ($urandom_range(0, 3) != 0);
            wr_en = $urandom_range(0, 1);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
            wr_mask = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
            commit = ($urandom_range(0, 2) == 0);
            clear = ($urandom_range(0, 24) == 0);
            preset = ($urandom_range(0, 24) == 0);
            rd_en_a = $urandom_range(0, 1);
            rd_en_b = $urandom_range(0, 1);
            rd_addr_a = 2'($urandom_range(0, 3));
            rd_addr_b = 2'($urandom_range(0, 3));
            step("rand");
        end

        // Asynchronous reset mid-run, then all addresses read back zero
        wr(2'd0, 8'h77, 8'hFF, 1'b0, 1'b1); step("rs_w");
        do_commit(); wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h33; wr_mask = 8'hFF; rd_en_a = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_model("rs_async");
        @(posedge clk);
        #1;
        cmp_model("rs_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), 2'(3 - a)); step("rs_rd");
            chk("rs_rd_a_zero", qa, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
